// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
//   Two-requester round-robin arbiter feeding a single registered output
//   stage. The grant selects a 2:1 data mux; the winner's data is captured
//   into the output register whenever that register is empty or draining.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   [1:0] per-requester valid
//   in0_data   requester 0 data
//   in1_data   requester 1 data
//   in_ready   [1:0] per-requester accept (one-hot or zero)
//   out_valid  output register holds valid data
//   out_ready  consumer accepts out_data this cycle
//   out_data   registered muxed data
//   out_sel    index of the requester whose data is in out_data
//
// Optional build macro MUX2_RR_ARBITER_STATS_EN adds:
//   stats_clr  synchronous clear of both grant counters (wins over increment)
//   grant_cnt0 saturating count of accepted transfers from requester 0
//   grant_cnt1 saturating count of accepted transfers from requester 1

module mux2_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       in_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic [WIDTH-1:0] in1_data,
    output logic [1:0]       in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel
`ifdef MUX2_RR_ARBITER_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    logic       last_grant;
    logic       load_en;
    logic       has_winner;
    logic       winner;
    logic [1:0] xfer;

    // Output stage can take new data when empty or being drained this cycle.
    assign load_en    = !out_valid || out_ready;
    assign has_winner = |in_valid;

    // On a tie the pointer decides; otherwise the single valid requester wins
    // (in_valid[1] is exactly its index when only one bit is set).
    always_comb begin
        winner = in_valid[1];
        if (in_valid == 2'b11)
            winner = ~last_grant;
    end

    // rst_n gating keeps in_ready low for the whole reset window, even though
    // the empty output stage would otherwise make load_en true.
    always_comb begin
        in_ready = 2'b00;
        if (rst_n && load_en && has_winner)
            in_ready[winner] = 1'b1;
    end

    assign xfer = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= 1'b0;
            last_grant <= 1'b1;   // requester 0 wins the first tie
        end else if (load_en) begin
            if (has_winner) begin
                out_data   <= winner ? in1_data : in0_data;
                out_sel    <= winner;
                out_valid  <= 1'b1;
                last_grant <= winner;
            end else begin
                // Nothing to load: drop valid, leave data/sel untouched.
                out_valid  <= 1'b0;
            end
        end
    end

`ifdef MUX2_RR_ARBITER_STATS_EN
    logic [1:0][CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (stats_clr) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (xfer[i] && (cnt[i] != {CNT_W{1'b1}}))
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    assign grant_cnt0 = cnt[0];
    assign grant_cnt1 = cnt[1];
`else
    // Transfer vector only feeds the counters; keep it observed otherwise.
    logic unused_xfer;
    assign unused_xfer = ^xfer;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed-vector bench for mux2_rr_arbiter. Stimulus pushes the hand-computed
// output beat into a queue when an input handshake is issued; a monitor pops
// and compares whenever the output handshake fires.

module tb_mux2_rr_arbiter;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       in_valid;
    logic [WIDTH-1:0] in0_data;
    logic [WIDTH-1:0] in1_data;
    logic [1:0]       in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
`ifdef MUX2_RR_ARBITER_STATS_EN
    logic             stats_clr;
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;
`endif

    mux2_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in0_data  (in0_data),
        .in1_data  (in1_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
`ifdef MUX2_RR_ARBITER_STATS_EN
        ,
        .stats_clr (stats_clr),
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sel;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: output handshake is sampled mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL monitor_unexpected: got data %0h sel %0d with empty queue", out_data, out_sel);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("mon_data", 32'(out_data), 32'(e.data));
                chk("mon_sel",  32'(out_sel),  32'(e.sel));
            end
        end
    end

    // Issue one cycle of input; check in_ready and queue the expected beat.
    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic ordy, input logic [1:0] exp_rdy, input string name);
        in_valid  = v;
        in0_data  = d0;
        in1_data  = d1;
        out_ready = ordy;
        #2;
        chk(name, 32'(in_ready), 32'(exp_rdy));
        if (exp_rdy == 2'b01) exp_q.push_back('{data: d0, sel: 1'b0});
        if (exp_rdy == 2'b10) exp_q.push_back('{data: d1, sel: 1'b1});
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 2'b11;
        in0_data  = 8'h11;
        in1_data  = 8'h22;
        out_ready = 1'b1;
`ifdef MUX2_RR_ARBITER_STATS_EN
        stats_clr = 1'b0;
`endif
        // Reset state with both requesters asserting.
        repeat (2) @(posedge clk);
        #2;
        chk("rst_in_ready",  32'(in_ready),  32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_out_sel",   32'(out_sel),   32'h0);
        in_valid = 2'b00;
        rst_n    = 1'b1;
        step();

        // Contention: first tie goes to 0, then strict alternation.
        drive(2'b11, 8'h11, 8'h22, 1'b1, 2'b01, "cont0");
        drive(2'b11, 8'h11, 8'h22, 1'b1, 2'b10, "cont1");
        drive(2'b11, 8'h11, 8'h22, 1'b1, 2'b01, "cont2");
        drive(2'b11, 8'h11, 8'h22, 1'b1, 2'b10, "cont3");

        // Single requester.
        drive(2'b01, 8'hA5, 8'h00, 1'b1, 2'b01, "single0");
        chk("single_out_valid", 32'(out_valid), 32'h1);
        chk("single_out_data",  32'(out_data),  32'hA5);

        // Back-pressure: load 33 from requester 1, then stall 3 cycles.
        drive(2'b10, 8'h00, 8'h33, 1'b1, 2'b10, "bp_load");
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 8'h44, 8'h55, 1'b0, 2'b00, "bp_in_ready");
            chk("bp_out_data",  32'(out_data),  32'h33);
            chk("bp_out_valid", 32'(out_valid), 32'h1);
        end
        // Release: pointer was 1, so requester 0 loads in the draining cycle.
        drive(2'b11, 8'h44, 8'h55, 1'b1, 2'b01, "bp_release");
        chk("nobubble_valid", 32'(out_valid), 32'h1);
        chk("nobubble_data",  32'(out_data),  32'h44);

        // Pointer hold: requester 1 asks while stalled, no transfer happens.
        drive(2'b10, 8'h00, 8'h66, 1'b0, 2'b00, "hold_stall");
        drive(2'b11, 8'h77, 8'h66, 1'b1, 2'b10, "hold_tie");

        // No winner drains the stage.
        drive(2'b00, 8'h00, 8'h00, 1'b1, 2'b00, "idle");
        chk("idle_out_valid", 32'(out_valid), 32'h0);
        chk("idle_out_data",  32'(out_data),  32'h66);
        chk("idle_out_sel",   32'(out_sel),   32'h1);

        // Async reset mid-stream: load 0x77, stall, reset between edges.
        in_valid  = 2'b01;
        in0_data  = 8'h77;
        out_ready = 1'b1;
        step();
        in_valid  = 2'b00;
        out_ready = 1'b0;
        chk("pre_rst_data", 32'(out_data), 32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_ready", 32'(in_ready),  32'h0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();

`ifdef MUX2_RR_ARBITER_STATS_EN
        chk("cnt0_after_rst", 32'(grant_cnt0), 32'h0);
        chk("cnt1_after_rst", 32'(grant_cnt1), 32'h0);
        drive(2'b10, 8'h00, 8'h81, 1'b1, 2'b10, "stat_g0");
        drive(2'b10, 8'h00, 8'h82, 1'b1, 2'b10, "stat_g1");
        drive(2'b10, 8'h00, 8'h83, 1'b1, 2'b10, "stat_g2");
        in_valid = 2'b00;
        chk("cnt1_three", 32'(grant_cnt1), 32'h3);
        chk("cnt0_zero",  32'(grant_cnt0), 32'h0);
        // Clear wins over a same-cycle increment.
        stats_clr = 1'b1;
        drive(2'b10, 8'h00, 8'h84, 1'b1, 2'b10, "stat_clr");
        stats_clr = 1'b0;
        chk("cnt1_cleared", 32'(grant_cnt1), 32'h0);
`endif

        // Drain with a bounded wait.
        in_valid  = 2'b00;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
